traffic_sensor_conditioner: RTL

TRAFFIC_SENSOR_CONDITIONER -- requirements
Module: traffic_sensor_conditioner

---
 rtl/traffic_sensor_conditioner.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/traffic_sensor_conditioner.sv
// Road-sensor front end: synchronises two bouncing car-presence inputs and debounces them
// on a shared prescaled tick, giving glitch-free presence levels plus arrival pulses.

module traffic_sensor_conditioner_chan #(
    parameter int unsigned DB_TICKS = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic tick_i,
    input  logic sync_i,
    output logic s_o,
    output logic arr_o
);

    localparam int unsigned CW = (DB_TICKS > 1) ? $clog2(DB_TICKS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_TICKS - 1);

    typedef enum logic [1:0] {
        LOW    = 2'd0,
        ARM_HI = 2'd1,
        HIGH   = 2'd2,
        ARM_LO = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          s_q, s_d;
    logic          arr_q, arr_d;

    // A sync reversal is tested before the tick, so it wins over a completing tick.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            LOW: begin
                if (sync_i) begin
                    state_d = ARM_HI;
                    cnt_d   = '0;
                end
            end
            ARM_HI: begin
                if (!sync_i) begin
                    state_d = LOW;
                    cnt_d   = '0;
                end else if (tick_i) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = HIGH;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            HIGH: begin
                if (!sync_i) begin
                    state_d = ARM_LO;
                    cnt_d   = '0;
                end
            end
            ARM_LO: begin
                if (sync_i) begin
                    state_d = HIGH;
                    cnt_d   = '0;
                end else if (tick_i) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = LOW;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d = LOW;
                cnt_d   = '0;
            end
        endcase

        // Outputs are decoded from the next state and registered alongside it.
        s_d   = (state_d == HIGH) || (state_d == ARM_LO);
        arr_d = (state_q == ARM_HI) && (state_d == HIGH);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= LOW;
            cnt_q   <= '0;
            s_q     <= 1'b0;
            arr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            arr_q   <= arr_d;
        end
    end

    assign s_o   = s_q;
    assign arr_o = arr_q;

endmodule

module traffic_sensor_conditioner #(
    parameter int unsigned TICK_DIV = 4,
    parameter int unsigned DB_TICKS = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_a,
    input  logic raw_b,
    output logic tick,
    output logic Sa,
    output logic Sb,
    output logic arr_a,
    output logic arr_b
);

    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] pre_q, pre_d;
    logic [1:0]    sync_a_q, sync_b_q;

    always_comb begin
        if (pre_q == PRE_LAST) begin
            pre_d = '0;
        end else begin
            pre_d = pre_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_q    <= '0;
            sync_a_q <= '0;
            sync_b_q <= '0;
        end else begin
            pre_q    <= pre_d;
            sync_a_q <= {sync_a_q[0], raw_a};
            sync_b_q <= {sync_b_q[0], raw_b};
        end
    end

    assign tick = (pre_q == PRE_LAST);

    traffic_sensor_conditioner_chan #(
        .DB_TICKS(DB_TICKS)
    ) u_chan_a (
        .clk    (clk),
        .reset  (reset),
        .tick_i (tick),
        .sync_i (sync_a_q[1]),
        .s_o    (Sa),
        .arr_o  (arr_a)
    );

    traffic_sensor_conditioner_chan #(
        .DB_TICKS(DB_TICKS)
    ) u_chan_b (
        .clk    (clk),
        .reset  (reset),
        .tick_i (tick),
        .sync_i (sync_b_q[1]),
        .s_o    (Sb),
        .arr_o  (arr_b)
    );

endmodule
